rv32_alu: RTL and testbench
===========================

Name: rv32_alu

Overview:
- Execute-stage ALU of the 32-bit RV32I pipeline.
- Computes the arithmetic/logic result, the effective address, the branch/jump target or the upper-immediate value from operands A, B, the sign-extended immediate and the instruction PC.
- Evaluates the branch condition.
- Outputs are registered and feed the MEM pipeline state (ALUOutput, branch).

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- i_clk  in  1  pipeline clock, rising edge
- i_reset  in  1  asynchronous reset, active low (0 = reset)
- i_A  in  32  rs1 operand (rd1)
- i_B  in  32  rs2 operand (rd2)
- i_Imm_SignExt  in  32  sign-extended immediate, already formatted per instruction type
- i_NPC  in  32  PC of the instruction in EX
- i_ALUop  in  3  operation class (encoding below)
- i_func3  in  3  instruction funct3
- i_func7  in  1  instruction bit 30 (funct7[5])
- o_ALUOutput  out  32  registered result
- o_branch  out  1  registered taken flag (branch taken or jump)

Behaviour:
- i_ALUop encoding:
  - 000 OP (R-type)
  - 001 OP-IMM
  - 010 LOAD/STORE
  - 011 BRANCH
  - 100 LUI
  - 101 AUIPC
  - 110 JAL
  - 111 JALR
- Latency: result computed combinationally; captured on every rising i_clk; visible one cycle after inputs. No enable, no stall.
- Reset: while i_reset=0, o_ALUOutput=0 and o_branch=0, asynchronously. Outputs resume capturing on the first rising edge after release.
- OP, operand2=i_B, by func3:
  - 000: ADD, or SUB when i_func7=1
  - 001: SLL
  - 010: SLT (signed)
  - 011: SLTU
  - 100: XOR
  - 101: SRL, or SRA when i_func7=1
  - 110: OR
  - 111: AND
- OP-IMM, operand2=i_Imm_SignExt: same table, except:
  - func3 000 is always ADD; i_func7 ignored.
  - func3 101 uses i_func7 for SRLI/SRAI.
- Shifts use operand2[4:0] only; upper bits ignored. Shift by 0 returns A unchanged.
- SLT/SLTU write 32'd1 or 32'd0.
- Add/sub wrap modulo 2^32; no overflow flag.
- o_branch=0 for OP, OP-IMM, LOAD/STORE, LUI, AUIPC.
- LOAD/STORE: A + Imm (effective address).
- LUI: Imm (upper immediate already positioned).
- AUIPC: NPC + Imm.
- BRANCH: output NPC + Imm (target). o_branch by func3:
  - 000 A==B
  - 001 A!=B
  - 100 signed A<B
  - 101 signed A>=B
  - 110 unsigned A<B
  - 111 unsigned A>=B
  - 010/011 reserved: o_branch=0
- JAL: output NPC + Imm; o_branch=1.
- JALR: output (A + Imm) with bit 0 cleared; o_branch=1.
- No internal state beyond the output registers; each cycle is independent.

Optional Feature:
- Macro ALU_RETADDR_EN.
- When defined: adds port o_retaddr (out, 32), registered with the same timing as the other outputs, reset to 0, carrying i_NPC + 4 for every ALUop (link address for JAL/JALR).
- When undefined: the port and its register do not exist; all other behaviour is identical.

Test Plan:
- Reset: drive i_reset=0 mid-operation with nonzero outputs -> o_ALUOutput=0, o_branch=0 immediately, without waiting for a clock edge.
- OP, A=0x7FFFFFFF, B=1, func3=000:
  - func7=0 -> 0x80000000 next cycle.
  - func7=1 with A=0, B=1 -> 0xFFFFFFFF.
- Shifts, A=0x80000000, B=0x00000021:
  - SRL -> 0x40000000 (shamt=1).
  - SRA -> 0xC0000000.
  - OP-IMM SRAI with Imm=0x401 (func7=1) -> 0xC0000000.
- Compare, A=0xFFFFFFFF, B=1:
  - SLT -> 1, SLTU -> 0.
  - BLT (func3=100) -> o_branch=1; BLTU (110) -> o_branch=0.
  - Output NPC+Imm, e.g. NPC=0x100, Imm=0xFFFFFFF0 -> 0xF0.
- Upper/jumps, NPC=0x1000:
  - LUI Imm=0x12345000 -> 0x12345000.
  - AUIPC -> 0x12346000.
  - JALR A=0x2001, Imm=2 -> 0x2002, o_branch=1.
  - OP-IMM func3=000 with func7=1, A=5, Imm=3 -> 8 (no subtract).

Source files
------------

// File: rtl/rv32_alu_if.sv
// Operand/result bundle between the RV32I decode/EX boundary and the EX-stage ALU.
// o_retaddr exists only when ALU_RETADDR_EN is defined.
interface rv32_alu_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] i_A;
  logic [XLEN-1:0] i_B;
  logic [XLEN-1:0] i_Imm_SignExt;
  logic [XLEN-1:0] i_NPC;
  logic [2:0]      i_ALUop;
  logic [2:0]      i_func3;
  logic            i_func7;
  logic [XLEN-1:0] o_ALUOutput;
  logic            o_branch;
`ifdef ALU_RETADDR_EN
  logic [XLEN-1:0] o_retaddr;
`endif

  modport master (
    output i_A, i_B, i_Imm_SignExt, i_NPC, i_ALUop, i_func3, i_func7,
`ifdef ALU_RETADDR_EN
    input  o_retaddr,
`endif
    input  o_ALUOutput, o_branch
  );

  modport slave (
    input  i_A, i_B, i_Imm_SignExt, i_NPC, i_ALUop, i_func3, i_func7,
`ifdef ALU_RETADDR_EN
    output o_retaddr,
`endif
    output o_ALUOutput, o_branch
  );
endinterface

// File: rtl/rv32_alu.sv
// RV32I execute-stage ALU: result/address/target plus branch decision, registered into EX/MEM.
// Optional link-address output (NPC+4) enabled by defining ALU_RETADDR_EN.
module rv32_alu #(
  parameter int XLEN = 32   // only 32 is supported
) (
  input  logic        i_clk,
  input  logic        i_reset,
  rv32_alu_if.slave   bus
);
  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_IMM  = 3'b001;
  localparam logic [2:0] OP_LDST = 3'b010;
  localparam logic [2:0] OP_BR   = 3'b011;
  localparam logic [2:0] OP_LUI  = 3'b100;
  localparam logic [2:0] OP_AUI  = 3'b101;
  localparam logic [2:0] OP_JAL  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  logic [XLEN-1:0] w_op2;
  logic            w_sub;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_pc_sum;
  logic [4:0]      w_shamt;
  logic            w_lt;
  logic            w_ltu;
  logic            w_eq;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_res;
  logic            w_br;

  logic [XLEN-1:0] r_ALUOutput;
  logic            r_branch;

  // Only register-register ADD can become SUB; ADDI ignores bit 30.
  assign w_op2    = (bus.i_ALUop == OP_R) ? bus.i_B : bus.i_Imm_SignExt;
  assign w_sub    = (bus.i_ALUop == OP_R) && (bus.i_func3 == 3'b000) && bus.i_func7;
  assign w_sum    = bus.i_A + (w_sub ? ~w_op2 : w_op2) + {{(XLEN-1){1'b0}}, w_sub};
  assign w_pc_sum = bus.i_NPC + bus.i_Imm_SignExt;
  assign w_shamt  = w_op2[4:0];
  assign w_lt     = $signed(bus.i_A) < $signed(w_op2);
  assign w_ltu    = bus.i_A < w_op2;
  assign w_eq     = bus.i_A == bus.i_B;

  always_comb begin
    w_alu = '0;
    unique case (bus.i_func3)
      3'b000: w_alu = w_sum;
      3'b001: w_alu = bus.i_A << w_shamt;
      3'b010: w_alu = {{(XLEN-1){1'b0}}, w_lt};
      3'b011: w_alu = {{(XLEN-1){1'b0}}, w_ltu};
      3'b100: w_alu = bus.i_A ^ w_op2;
      3'b101: w_alu = bus.i_func7 ? XLEN'($signed(bus.i_A) >>> w_shamt)
                                  : bus.i_A >> w_shamt;
      3'b110: w_alu = bus.i_A | w_op2;
      3'b111: w_alu = bus.i_A & w_op2;
      default: w_alu = '0;
    endcase
  end

  // Branch compares always use rs2; w_op2 is only i_B for OP, so compare directly here.
  always_comb begin
    w_res = '0;
    w_br  = 1'b0;
    unique case (bus.i_ALUop)
      OP_R, OP_IMM: w_res = w_alu;
      OP_LDST:      w_res = w_sum;
      OP_BR: begin
        w_res = w_pc_sum;
        unique case (bus.i_func3)
          3'b000: w_br = w_eq;
          3'b001: w_br = ~w_eq;
          3'b100: w_br = $signed(bus.i_A) <  $signed(bus.i_B);
          3'b101: w_br = $signed(bus.i_A) >= $signed(bus.i_B);
          3'b110: w_br = bus.i_A <  bus.i_B;
          3'b111: w_br = bus.i_A >= bus.i_B;
          default: w_br = 1'b0;
        endcase
      end
      OP_LUI:  w_res = bus.i_Imm_SignExt;
      OP_AUI:  w_res = w_pc_sum;
      OP_JAL: begin
        w_res = w_pc_sum;
        w_br  = 1'b1;
      end
      OP_JALR: begin
        w_res = {w_sum[XLEN-1:1], 1'b0};
        w_br  = 1'b1;
      end
      default: begin
        w_res = '0;
        w_br  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ALUOutput <= '0;
      r_branch    <= 1'b0;
    end else begin
      r_ALUOutput <= w_res;
      r_branch    <= w_br;
    end
  end

  assign bus.o_ALUOutput = r_ALUOutput;
  assign bus.o_branch    = r_branch;

`ifdef ALU_RETADDR_EN
  logic [XLEN-1:0] r_retaddr;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_retaddr <= '0;
    else          r_retaddr <= bus.i_NPC + XLEN'(4);
  end

  assign bus.o_retaddr = r_retaddr;
`endif
endmodule

// File: tb/tb_rv32_alu.sv
// Directed scoreboard bench for rv32_alu: expected results queued at drive time, checked after the capturing edge.
module tb_rv32_alu;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  typedef struct {
    string       tag;
    logic [31:0] out;
    logic        br;
    logic [31:0] ret;
  } exp_t;

  exp_t sb[$];

  rv32_alu_if #(.XLEN(32)) bus ();

  rv32_alu #(.XLEN(32)) u_dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input string tag, input logic [2:0] op, input logic [2:0] f3,
                       input logic f7, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] npc,
                       input logic [31:0] exp_out, input logic exp_br);
    exp_t e;
    bus.i_ALUop = op; bus.i_func3 = f3; bus.i_func7 = f7;
    bus.i_A = a; bus.i_B = b; bus.i_Imm_SignExt = imm; bus.i_NPC = npc;
    e.tag = tag; e.out = exp_out; e.br = exp_br; e.ret = npc + 32'd4;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_vec++;
    assert (bus.o_ALUOutput === e.out) else begin
      n_err++;
      $error("FAIL %s.out: got %h expected %h", e.tag, bus.o_ALUOutput, e.out);
    end
    n_vec++;
    assert (bus.o_branch === e.br) else begin
      n_err++;
      $error("FAIL %s.br: got %b expected %b", e.tag, bus.o_branch, e.br);
    end
`ifdef ALU_RETADDR_EN
    n_vec++;
    assert (bus.o_retaddr === e.ret) else begin
      n_err++;
      $error("FAIL %s.ret: got %h expected %h", e.tag, bus.o_retaddr, e.ret);
    end
`endif
  endtask

  task automatic chk_zero(input string tag);
    n_vec++;
    assert (bus.o_ALUOutput === 32'h0) else begin
      n_err++;
      $error("FAIL %s.out: got %h expected 00000000", tag, bus.o_ALUOutput);
    end
    n_vec++;
    assert (bus.o_branch === 1'b0) else begin
      n_err++;
      $error("FAIL %s.br: got %b expected 0", tag, bus.o_branch);
    end
`ifdef ALU_RETADDR_EN
    n_vec++;
    assert (bus.o_retaddr === 32'h0) else begin
      n_err++;
      $error("FAIL %s.ret: got %h expected 00000000", tag, bus.o_retaddr);
    end
`endif
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.i_ALUop = 3'b110; bus.i_func3 = 3'b000; bus.i_func7 = 1'b0;
    bus.i_A = 32'h0; bus.i_B = 32'h0; bus.i_Imm_SignExt = 32'h44; bus.i_NPC = 32'h1000;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_init");
    @(posedge clk); #1;
    chk_zero("rst_hold");
    #2 rst_n = 1'b1;

    //    tag          op      f3      f7    A             B             Imm           NPC           out           br
    drive("add_wrap",  3'b000, 3'b000, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h0,        32'h0,        32'h80000000, 1'b0);
    drive("sub",       3'b000, 3'b000, 1'b1, 32'h00000000, 32'h00000001, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0);
    drive("srl",       3'b000, 3'b101, 1'b0, 32'h80000000, 32'h00000021, 32'h0,        32'h0,        32'h40000000, 1'b0);
    drive("sra",       3'b000, 3'b101, 1'b1, 32'h80000000, 32'h00000021, 32'h0,        32'h0,        32'hC0000000, 1'b0);
    drive("srai",      3'b001, 3'b101, 1'b1, 32'h80000000, 32'h00000000, 32'h00000401, 32'h0,        32'hC0000000, 1'b0);
    drive("sll_sh0",   3'b000, 3'b001, 1'b0, 32'h12345678, 32'h00000020, 32'h0,        32'h0,        32'h12345678, 1'b0);
    drive("slli",      3'b001, 3'b001, 1'b0, 32'h00000003, 32'h0,        32'h00000004, 32'h0,        32'h00000030, 1'b0);
    drive("slt",       3'b000, 3'b010, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0,        32'h00000001, 1'b0);
    drive("sltu",      3'b000, 3'b011, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0,        32'h00000000, 1'b0);
    drive("xor",       3'b000, 3'b100, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'h0,        32'h0FF00FF0, 1'b0);
    drive("or",        3'b000, 3'b110, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'h0,        32'hFFF0FFF0, 1'b0);
    drive("and",       3'b000, 3'b111, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'h0,        32'hF000F000, 1'b0);
    drive("addi_f7",   3'b001, 3'b000, 1'b1, 32'h00000005, 32'h00000009, 32'h00000003, 32'h0,        32'h00000008, 1'b0);
    drive("ldst",      3'b010, 3'b010, 1'b0, 32'h00001000, 32'h0,        32'hFFFFFFFC, 32'h0,        32'h00000FFC, 1'b0);
    drive("blt",       3'b011, 3'b100, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFF0, 32'h00000100, 32'h000000F0, 1'b1);
    drive("bltu",      3'b011, 3'b110, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFF0, 32'h00000100, 32'h000000F0, 1'b0);
    drive("bge",       3'b011, 3'b101, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h8,        32'h00000200, 32'h00000208, 1'b0);
    drive("bgeu",      3'b011, 3'b111, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h8,        32'h00000200, 32'h00000208, 1'b1);
    drive("beq",       3'b011, 3'b000, 1'b0, 32'h00000005, 32'h00000005, 32'h8,        32'h00000200, 32'h00000208, 1'b1);
    drive("bne_eq",    3'b011, 3'b001, 1'b0, 32'h00000005, 32'h00000005, 32'h8,        32'h00000200, 32'h00000208, 1'b0);
    drive("br_resv",   3'b011, 3'b010, 1'b0, 32'h00000005, 32'h00000005, 32'h8,        32'h00000200, 32'h00000208, 1'b0);
    drive("lui",       3'b100, 3'b000, 1'b0, 32'hDEADBEEF, 32'h0,        32'h12345000, 32'h00001000, 32'h12345000, 1'b0);
    drive("auipc",     3'b101, 3'b000, 1'b0, 32'hDEADBEEF, 32'h0,        32'h12345000, 32'h00001000, 32'h12346000, 1'b0);
    drive("jal",       3'b110, 3'b000, 1'b0, 32'h0,        32'h0,        32'h00000020, 32'h00000400, 32'h00000420, 1'b1);
    drive("jalr",      3'b111, 3'b000, 1'b0, 32'h00002001, 32'h0,        32'h00000002, 32'h00001000, 32'h00002002, 1'b1);

    // Outputs are nonzero (jalr) here; reset must clear them before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk_zero("rst_async");
    #1 rst_n = 1'b1;
    drive("post_rst",  3'b000, 3'b000, 1'b0, 32'h00000002, 32'h00000003, 32'h0,        32'h00000010, 32'h00000005, 1'b0);

    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $error("FAIL scoreboard: got %0d left expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
